// File: rtl/adder_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter_if
// Groups the requester, adder and response signals of the shared-adder
// arbiter into one bundle.
//   req_valid/req_ready/req_a/req_b/req_cin : requester side (packed per id)
//   add_a/add_b/add_cin/add_sum/add_cout    : shared adder wrapper side
//   rsp_valid/rsp_id/rsp_sum/rsp_cout       : result return side
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system (clients + adder wrapper)
// -----------------------------------------------------------------------------
interface adder_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic [NREQ-1:0]       rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        output req_ready, add_a, add_b, add_cin,
               rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout,
        input  req_ready, add_a, add_b, add_cin,
               rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
// Shares one fixed-latency pipelined adder between NREQ requesters. A
// round-robin arbiter grants at most one request per cycle, registers the
// winner's operands toward the adder, and carries the winner's id down a tag
// pipeline aligned with the adder latency so the result is returned to the
// requester that issued it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        adder_share_arbiter_if.slave (requests, adder, responses)
// Optional (macro ADD_ARB_STATS_EN defined):
//   stats_clr  synchronous clear of the grant counters
//   grant_cnt  NREQ x 32-bit wrapping grant counters, requester i at [i*32 +: 32]
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int LAT   = 2,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
`ifdef ADD_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NREQ*32-1:0]    grant_cnt
`endif
);

    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  at_or_above;
    logic [NREQ-1:0]  upper_req;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gnt_idx;
    logic             any_req;
    logic             issue;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;

    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             add_cin_q;

    logic             tag_vld [0:LAT];
    logic [IDW-1:0]   tag_id  [0:LAT];

    logic [NREQ-1:0]  rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;

    // Round-robin pick: lowest valid index at or above rr_ptr; if none, the
    // search wraps and the lowest valid index overall wins.
    always_comb begin
        at_or_above = '0;
        for (int i = 0; i < NREQ; i++) begin
            at_or_above[i] = (IDW'(i) >= rr_ptr);
        end
        upper_req = bus.req_valid & at_or_above;
        any_req   = |bus.req_valid;
        gnt_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) gnt_idx = IDW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (upper_req[i]) gnt_idx = IDW'(i);
        end
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any_req && (gnt_idx == IDW'(i));
        end
    end

    assign issue = |(bus.req_valid & grant);

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = bus.req_a[i*WIDTH +: WIDTH];
                sel_b   = bus.req_b[i*WIDTH +: WIDTH];
                sel_cin = bus.req_cin[i];
            end
        end
    end

    // Operand register and pointer; both hold when nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else if (issue) begin
            add_a_q   <= sel_a;
            add_b_q   <= sel_b;
            add_cin_q <= sel_cin;
            rr_ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    // Tag pipe never stalls: the adder has no backpressure. Stage LAT lines up
    // with add_sum for the operands issued LAT+1 cycles earlier. Clearing it on
    // reset drops results the adder may still emit for pre-reset issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_id[0]  <= gnt_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else if (tag_vld[LAT]) begin
            rsp_valid_q <= NREQ'(1) << tag_id[LAT];
            rsp_id_q    <= tag_id[LAT];
            rsp_sum_q   <= bus.add_sum;
            rsp_cout_q  <= bus.add_cout;
        end else begin
            rsp_valid_q <= '0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;

`ifdef ADD_ARB_STATS_EN
    logic [31:0] cnt [NREQ];

    // Clear wins over a coincident issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && bus.req_valid[i]) cnt[i] <= cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*32 +: 32] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
// Directed vectors with hand-written expected grants. Each expected grant
// pushes the expected result into a queue; a negedge monitor pops and compares
// whenever rsp_valid is seen. The shared adder is modelled as a two-register
// wrapper (input register, then registered sum) with no reset, so it keeps
// emitting in-flight results across a DUT reset.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int LAT   = 2;
    localparam int IDW   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef ADD_ARB_STATS_EN
    logic                 stats_clr = 1'b0;
    logic [NREQ*32-1:0]   grant_cnt;
`endif

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave)
`ifdef ADD_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    // Adder wrapper model: LAT = 2
    logic [63:0] s1_a, s1_b, s2_s;
    logic        s1_c, s2_c;
    always @(posedge clk) begin
        s1_a <= bus.add_a;
        s1_b <= bus.add_b;
        s1_c <= bus.add_cin;
        {s2_c, s2_s} <= {1'b0, s1_a} + {1'b0, s1_b} + 65'(s1_c);
    end
    assign bus.add_sum  = s2_s;
    assign bus.add_cout = s2_c;

    logic [63:0] a_op [NREQ];
    logic [63:0] b_op [NREQ];
    logic        cin_op [NREQ];

    always_comb begin
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.req_cin = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = a_op[i];
            bus.req_b[i*WIDTH +: WIDTH] = b_op[i];
            bus.req_cin[i]              = cin_op[i];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [63:0] sum;
        logic        cout;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // Response monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 128'(bus.rsp_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 128'(bus.rsp_valid), 128'(1) << e.id);
                check("rsp_id",    128'(bus.rsp_id),    128'(e.id));
                check("rsp_sum",   128'(bus.rsp_sum),   128'(e.sum));
                check("rsp_cout",  128'(bus.rsp_cout),  128'(e.cout));
                check("latency",   128'(cyc),           128'(e.cyc + LAT + 2));
            end
        end
    end

    // One cycle of stimulus: present v, expect grant g, log expected result.
    task automatic step(input logic [3:0] v, input logic [3:0] g);
        int          idx;
        logic [63:0] s;
        logic        c;
        idx = 0;
        bus.req_valid = v;
        @(negedge clk);
        check("grant", 128'(bus.req_ready), 128'(g));
        if (g != 4'b0) begin
            for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
            {c, s} = {1'b0, a_op[idx]} + {1'b0, b_op[idx]} + 65'(cin_op[idx]);
            exp_q.push_back('{idx, s, c, cyc});
        end
        @(posedge clk);
        #1;
        if (g != 4'b0) begin
            // granted requester moves on to a fresh operand set
            a_op[idx]   = a_op[idx] * 64'd7 + 64'h0123_4567_89AB_CDEF;
            b_op[idx]   = b_op[idx] + 64'hF000_0000_0000_0001;
            cin_op[idx] = ~cin_op[idx];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 4'b0000);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst_add_a",     128'(bus.add_a),     128'(0));
        check("rst_add_b",     128'(bus.add_b),     128'(0));
        check("rst_add_cin",   128'(bus.add_cin),   128'(0));
        check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst_rsp_id",    128'(bus.rsp_id),    128'(0));
        check("rst_rsp_sum",   128'(bus.rsp_sum),   128'(0));
        check("rst_rsp_cout",  128'(bus.rsp_cout),  128'(0));
        check("rst_req_ready", 128'(bus.req_ready), 128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = '0; b_op[i] = '0; cin_op[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // single request from requester 2: 1 + 2 + 1 = 4
        a_op[2] = 64'h1; b_op[2] = 64'h2; cin_op[2] = 1'b1;
        step(4'b0100, 4'b0100);
        idle(6);

        // overflow on requester 3 (pointer is now 3)
        a_op[3] = 64'hFFFF_FFFF_FFFF_FFFF; b_op[3] = 64'h1; cin_op[3] = 1'b0;
        step(4'b1000, 4'b1000);
        idle(6);

        // full contention from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_op[i]   = 64'h1000_0000_0000_0000 * 64'(i + 1) + 64'(i);
            b_op[i]   = 64'hDEAD_BEEF_0000_0000 + 64'(i * 3);
            cin_op[i] = i[0];
        end
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 4'b0001);
            step(4'b1111, 4'b0010);
            step(4'b1111, 4'b0100);
            step(4'b1111, 4'b1000);
        end
        idle(6);

        // pointer wrap/skip: pointer to 3, then only 1 and 3 compete
        step(4'b0100, 4'b0100);
        step(4'b1010, 4'b1000);
        step(4'b1010, 4'b0010);
        step(4'b1010, 4'b1000);
        step(4'b1011, 4'b0001);
        step(4'b1010, 4'b0010);
        idle(6);

        // withdraw: 1 loses to 0 then drops its request
        step(4'b1000, 4'b1000);
        step(4'b0011, 4'b0001);
        idle(7);

        // reset mid-flight (pointer is 1)
        step(4'b0010, 4'b0010);
        step(4'b0100, 4'b0100);
        step(4'b1000, 4'b1000);
        step(4'b0000, 4'b0000);
        do_reset();
        idle(6);
        step(4'b0001, 4'b0001);
        idle(7);

        check("drain", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
